// File: rtl/ls_arbiter.sv
// Local-store port arbiter: DMA > load/store > fetch, with a DMA burst lock.
// Optional fetch anti-starvation is compiled in with `define LS_ARB_STARVE_EN.
module ls_arbiter #(
   parameter int STARVE_LIMIT = 15,
   parameter int BURST_MAX    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         dma_valid,
   input  logic         ldst_valid,
   input  logic         if_valid,
   input  logic         dma_we,
   input  logic         ldst_we,
   input  logic         dma_last,
   input  logic [0:14]  dma_addr,
   input  logic [0:14]  ldst_addr,
   input  logic [0:14]  if_addr,
   input  logic [0:127] dma_wdata,
   input  logic [0:127] ldst_wdata,
   output logic         dma_ready,
   output logic         ldst_ready,
   output logic         if_ready,
   output logic         dma_rvalid,
   output logic         ldst_rvalid,
   output logic         if_rvalid,
   output logic [0:127] dma_rdata,
   output logic [0:127] ldst_rdata,
   output logic [0:127] if_rdata,
   output logic         mem_we,
   output logic [0:14]  mem_addr,
   output logic [0:127] mem_wdata,
   input  logic [0:127] mem_rdata
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [BW-1:0] BEAT_ONE = BW'(1);
   localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_MAX);

   state_t         state_q;
   logic [BW-1:0]  beat_q;
   logic           dma_rvalid_q, ldst_rvalid_q, if_rvalid_q;
   logic [0:127]   dma_rdata_q, ldst_rdata_q, if_rdata_q;
   logic           gnt_dma, gnt_ldst, gnt_if;
   logic           starve;

`ifdef LS_ARB_STARVE_EN
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);
   logic [WW-1:0] wait_q;

   assign starve = if_valid && (wait_q == WAIT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_q <= '0;
      else if (gnt_if)
         wait_q <= '0;
      else if (if_valid && (wait_q != WAIT_MAX))
         wait_q <= wait_q + WW'(1);
   end
`else
   assign starve = 1'b0;
`endif

   // Burst lock: while in BURST only DMA may own the port, even as a bubble.
   always_comb begin
      gnt_dma  = 1'b0;
      gnt_ldst = 1'b0;
      gnt_if   = 1'b0;
      if (state_q == BURST)
         gnt_dma = dma_valid;
      else if (starve)
         gnt_if = 1'b1;
      else if (dma_valid)
         gnt_dma = 1'b1;
      else if (ldst_valid)
         gnt_ldst = 1'b1;
      else if (if_valid)
         gnt_if = 1'b1;
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_dma) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else if (gnt_ldst) begin
         mem_we    = ldst_we;
         mem_addr  = ldst_addr;
         mem_wdata = ldst_wdata;
      end else if (gnt_if) begin
         mem_addr  = if_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         dma_rvalid_q  <= 1'b0;
         ldst_rvalid_q <= 1'b0;
         if_rvalid_q   <= 1'b0;
         dma_rdata_q   <= '0;
         ldst_rdata_q  <= '0;
         if_rdata_q    <= '0;
      end else begin
         dma_rvalid_q  <= gnt_dma && !dma_we;
         ldst_rvalid_q <= gnt_ldst && !ldst_we;
         if_rvalid_q   <= gnt_if;
         if (gnt_dma && !dma_we)   dma_rdata_q  <= mem_rdata;
         if (gnt_ldst && !ldst_we) ldst_rdata_q <= mem_rdata;
         if (gnt_if)               if_rdata_q   <= mem_rdata;

         case (state_q)
            IDLE: begin
               if (gnt_dma && !dma_last && (BURST_MAX > 1)) begin
                  state_q <= BURST;
                  beat_q  <= BEAT_ONE;
               end
            end
            BURST: begin
               // dma_last and the beat limit together still mean one release
               if (gnt_dma) begin
                  if (dma_last || (beat_q + BEAT_ONE == BEAT_MAX)) begin
                     state_q <= IDLE;
                     beat_q  <= '0;
                  end else begin
                     beat_q  <= beat_q + BEAT_ONE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               beat_q  <= '0;
            end
         endcase
      end
   end

   assign dma_ready   = gnt_dma;
   assign ldst_ready  = gnt_ldst;
   assign if_ready    = gnt_if;
   assign dma_rvalid  = dma_rvalid_q;
   assign ldst_rvalid = ldst_rvalid_q;
   assign if_rvalid   = if_rvalid_q;
   assign dma_rdata   = dma_rdata_q;
   assign ldst_rdata  = ldst_rdata_q;
   assign if_rdata    = if_rdata_q;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter; read responses are checked by a scoreboard monitor.
module tb_ls_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         dma_valid, ldst_valid, if_valid;
   logic         dma_we, ldst_we, dma_last;
   logic [0:14]  dma_addr, ldst_addr, if_addr;
   logic [0:127] dma_wdata, ldst_wdata;
   logic         dma_ready, ldst_ready, if_ready;
   logic         dma_rvalid, ldst_rvalid, if_rvalid;
   logic [0:127] dma_rdata, ldst_rdata, if_rdata;
   logic         mem_we;
   logic [0:14]  mem_addr;
   logic [0:127] mem_wdata, mem_rdata;

   logic [0:127] mem [0:2047];
   logic         init_mem = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int           ch;
      logic [0:127] d;
   } rsp_t;
   rsp_t exp_q[$];

   localparam logic [0:127] AA = {16{8'hAA}};
   localparam logic [0:127] V1234 = 128'h1234;

   always #5 clk = ~clk;

   ls_arbiter dut (
      .clk(clk), .rst(rst),
      .dma_valid(dma_valid), .ldst_valid(ldst_valid), .if_valid(if_valid),
      .dma_we(dma_we), .ldst_we(ldst_we), .dma_last(dma_last),
      .dma_addr(dma_addr), .ldst_addr(ldst_addr), .if_addr(if_addr),
      .dma_wdata(dma_wdata), .ldst_wdata(ldst_wdata),
      .dma_ready(dma_ready), .ldst_ready(ldst_ready), .if_ready(if_ready),
      .dma_rvalid(dma_rvalid), .ldst_rvalid(ldst_rvalid), .if_rvalid(if_rvalid),
      .dma_rdata(dma_rdata), .ldst_rdata(ldst_rdata), .if_rdata(if_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Local store model: quadword indexed, combinational read, clocked write.
   assign mem_rdata = mem[mem_addr[0:10]];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 2048; i++) mem[i] <= '0;
         mem[5] <= AA;
      end else if (mem_we) begin
         mem[mem_addr[0:10]] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [0:127] d);
      rsp_t r;
      r.ch = ch;
      r.d  = d;
      exp_q.push_back(r);
   endtask

   // Inputs are already driven; check readies mid-cycle then advance past the edge.
   task automatic step(input string nm, input logic [2:0] exp);
      @(negedge clk);
      chk(nm, {125'd0, dma_ready, ldst_ready, if_ready}, {125'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      dma_valid = 0; ldst_valid = 0; if_valid = 0;
      dma_we = 0; ldst_we = 0; dma_last = 1;
      dma_addr = '0; ldst_addr = '0; if_addr = '0;
      dma_wdata = '0; ldst_wdata = '0;
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && (dma_rvalid || ldst_rvalid || if_rvalid)) begin
         rsp_t e;
         int ch;
         logic [0:127] d;
         n_tests++;
         ch = dma_rvalid ? 0 : (ldst_rvalid ? 1 : 2);
         d  = dma_rvalid ? dma_rdata : (ldst_rvalid ? ldst_rdata : if_rdata);
         if ($countones({dma_rvalid, ldst_rvalid, if_rvalid}) != 1) begin
            n_fail++;
            $display("FAIL rsp_onehot: got rvalid %b required one-hot",
                     {dma_rvalid, ldst_rvalid, if_rvalid});
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got rvalid on ch %0d required none", ch);
         end else begin
            e = exp_q.pop_front();
            if (e.ch != ch || e.d !== d) begin
               n_fail++;
               $display("FAIL rsp_data: got ch %0d data %h required ch %0d data %h",
                        ch, d, e.ch, e.d);
            end
         end
      end
   end

   initial begin
      clear_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      init_mem = 0;

      // reset state
      @(negedge clk);
      chk("rst_ready", {125'd0, dma_ready, ldst_ready, if_ready}, 128'd0);
      chk("rst_rvalid", {125'd0, dma_rvalid, ldst_rvalid, if_rvalid}, 128'd0);
      chk("rst_rdata", dma_rdata | ldst_rdata | if_rdata, 128'd0);
      @(posedge clk);
      #1;

      // three-way contention: DMA wins
      dma_valid = 1; dma_addr = 15'h0050;
      ldst_valid = 1; ldst_addr = 15'h0050;
      if_valid = 1; if_addr = 15'h0050;
      push(0, AA);
      step("prio_all", 3'b100);
      clear_inputs();
      step("idle1", 3'b000);

      // write then read-after-write into the same quadword
      ldst_valid = 1; ldst_we = 1; ldst_addr = 15'h0050; ldst_wdata = V1234;
      step("ldst_wr", 3'b010);
      clear_inputs();
      if_valid = 1; if_addr = 15'h005F;
      push(2, V1234);
      step("if_raw", 3'b001);
      clear_inputs();
      step("idle2", 3'b000);
      step("idle3", 3'b000);
      @(negedge clk);
      chk("if_hold", if_rdata, V1234);
      @(posedge clk);
      #1;

      // 4-beat DMA write burst with a 2-cycle bubble while load/store waits
      ldst_valid = 1; ldst_addr = 15'h0050;
      dma_we = 1; dma_last = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            dma_valid = 0;
            step("burst_bubble_a", 3'b000);
            step("burst_bubble_b", 3'b000);
         end
         dma_valid = 1;
         dma_addr  = 15'(16'h0100 + 16 * i);
         dma_wdata = 128'hD000 + 128'(i);
         dma_last  = (i == 3);
         step("burst_beat", 3'b100);
      end
      dma_valid = 0;
      push(1, V1234);
      step("burst_release", 3'b010);
      clear_inputs();
      dma_valid = 1; dma_addr = 15'h0120;
      push(0, 128'hD002);
      step("burst_readback", 3'b100);
      clear_inputs();

      // forced release after BURST_MAX beats without dma_last
      ldst_valid = 1; ldst_we = 1; ldst_addr = 15'h0200; ldst_wdata = 128'h77;
      dma_valid = 1; dma_we = 1; dma_last = 0;
      for (int i = 0; i < 8; i++) begin
         dma_addr = 15'(16'h0400 + 16 * i);
         step("force_beat", 3'b100);
      end
      dma_valid = 0;
      step("force_idle", 3'b010);
      dma_valid = 1; dma_last = 1; dma_addr = 15'h0480;
      step("beat9_wins", 3'b100);
      clear_inputs();
      step("idle4", 3'b000);

      // fetch under continuous DMA and load/store pressure
      dma_valid = 1; dma_we = 1; dma_last = 1; dma_addr = 15'h0310;
      ldst_valid = 1; ldst_we = 1; ldst_addr = 15'h0300;
      if_valid = 1; if_addr = 15'h0050;
`ifdef LS_ARB_STARVE_EN
      for (int i = 1; i <= 15; i++) step("starve_wait", 3'b100);
      push(2, V1234);
      step("starve_grant", 3'b001);
      step("starve_cleared", 3'b100);
`else
      for (int i = 1; i <= 20; i++) step("strict_starve", 3'b100);
`endif
      clear_inputs();
      step("idle5", 3'b000);

      // reset during a BURST read beat with its response pending
      dma_valid = 1; dma_last = 0; dma_addr = 15'h0100;
      push(0, 128'hD000);
      step("rb_beat1", 3'b100);
      dma_addr = 15'h0110;
      @(negedge clk);
      chk("rb_beat2", {125'd0, dma_ready, ldst_ready, if_ready}, 128'b100);
      #2 rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      clear_inputs();
      ldst_valid = 1; ldst_addr = 15'h0050;
      @(negedge clk);
      chk("rb_rvalid", {125'd0, dma_rvalid, ldst_rvalid, if_rvalid}, 128'd0);
      chk("rb_rdata", dma_rdata, 128'd0);
      chk("rb_ldst_gnt", {125'd0, dma_ready, ldst_ready, if_ready}, 128'b010);
      push(1, V1234);
      @(posedge clk);
      #1;
      clear_inputs();
      step("idle6", 3'b000);
      step("idle7", 3'b000);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rsp_missing: got %0d responses outstanding required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ls_arbiter.md
# ls_arbiter

Arbiter and sequencer for the 2048 × 128-bit SPU local store. It shares the store's single port between three requesters: the DMA engine (MFC), the load/store pipe and instruction fetch. Each requester gets a valid/ready request channel and a registered read-response channel. The block drives the local store's write enable, address and write data, and captures its combinational read data.

## Interface
- `STARVE_LIMIT`, default 15: number of consecutive stalled instruction-fetch cycles before fetch is forced to top priority.
- `BURST_MAX`, default 8: maximum number of DMA beats held under one burst lock.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `dma_valid`, `ldst_valid`, `if_valid`  in  1 each  request valid
- `dma_we`, `ldst_we`  in  1 each  1 = write quadword, 0 = read; fetch is read-only
- `dma_last`  in  1  final beat of a DMA burst
- `dma_addr`, `ldst_addr`, `if_addr`  in  [0:14] each  byte address; bits [11:14] are ignored
- `dma_wdata`, `ldst_wdata`  in  [0:127] each  write data
- `dma_ready`, `ldst_ready`, `if_ready`  out  1 each  grant; the request is accepted this cycle
- `dma_rvalid`, `ldst_rvalid`, `if_rvalid`  out  1 each  read response valid
- `dma_rdata`, `ldst_rdata`, `if_rdata`  out  [0:127] each  read response data
- `mem_we`  out  1  local store write enable
- `mem_addr`  out  [0:14]  local store address
- `mem_wdata`  out  [0:127]  local store write data
- `mem_rdata`  in  [0:127]  local store combinational read data

## Operation
- **Handshake**
  - A requester holds valid and payload stable until it sees ready.
  - At most one ready is high per cycle. Ready is a combinational function of the valids and the registered state.
  - Ready never depends on its own requester's payload.
- **Port muxing**
  - The winner's `we`, `addr` and `wdata` are muxed onto `mem_*` combinationally in the grant cycle.
  - `mem_we` = winner `we` AND grant.
  - When there is no grant: `mem_we` = 0; `mem_addr` and `mem_wdata` = 0.
- **Normal priority:** DMA > load/store > fetch.
- **FSM states:** IDLE, BURST.
  - IDLE → BURST on a DMA grant with `dma_last` = 0. The beat counter is loaded with 1.
  - In BURST only DMA is eligible. Load/store and fetch ready are held at 0 even when DMA valid is low (bubble).
  - Each DMA grant in BURST increments the beat counter.
  - BURST → IDLE on a DMA grant with `dma_last` = 1, or on the grant where the beat count reaches `BURST_MAX` (forced release). The forced release ignores `dma_last`.
  - A DMA grant in IDLE with `dma_last` = 1 stays in IDLE (single beat).
- **Read responses**
  - A read grant registers `mem_rdata` into the requester's rdata register and pulses its rvalid for exactly one cycle, the cycle after the grant.
  - Writes produce no response.
  - Rdata registers hold their last value while rvalid = 0.
- **Fetch wait counter:** increments each cycle that `if_valid` = 1 and `if_ready` = 0. It saturates at `STARVE_LIMIT` and clears on a fetch grant. It counts in both states.
- **Writes:** a write and a read to the same address in consecutive cycles are legal. The read in cycle N+1 returns the data written in cycle N.

## Timing
- Grant latency: 0 cycles (ready in the request cycle when it wins). Read data latency: 1 cycle after the grant.
- Throughput: one access per cycle.
- Reset values (async, immediate):
  - State = IDLE; beat counter = 0; fetch wait counter = 0.
  - All rvalid = 0; all rdata = 0.
  - Ready outputs follow the combinational rules from IDLE.
- Reset in the middle of a burst aborts the burst and drops any pending rvalid. Local store contents are not touched by this block.
- A simultaneous `dma_last` and forced release produces a single return to IDLE.

## Configuration
- `LS_ARB_STARVE_EN` defined:
  - In IDLE, when the fetch wait counter equals `STARVE_LIMIT` and `if_valid` = 1, fetch beats both DMA and load/store.
  - BURST is never preempted.
- `LS_ARB_STARVE_EN` undefined:
  - Strict priority; the wait counter logic is not compiled.
  - Fetch may starve indefinitely.

## Test plan
- DMA, load/store and fetch reads valid in the same cycle, store preloaded with mem[5] = 0xAA..AA → `dma_ready` = 1 only; next cycle `dma_rvalid` = 1 with 0xAA..AA, other rvalid = 0.
- Load/store writes 0x1234 to addr 0x0050, then fetch reads addr 0x0050 next cycle → `if_rdata` = 0x1234 one cycle after the fetch grant. Addresses 0x0050 and 0x005F hit the same quadword.
- DMA 4-beat burst, `dma_valid` dropped for 2 cycles mid-burst while load/store is valid → `ldst_ready` stays 0 until the grant carrying `dma_last`; load/store is granted the next cycle.
- DMA burst with `dma_last` never asserted, `BURST_MAX` = 8 → forced return to IDLE after the 8th beat; the 9th DMA beat competes normally and wins over load/store.
- `LS_ARB_STARVE_EN` defined, DMA and load/store valid continuously, fetch valid → fetch granted on cycle 16 (counter reached 15); the counter returns to 0. With the macro undefined, fetch is never granted.
- Assert rst during a BURST beat that has a read grant pending → the next cycle has rvalid = 0 on all channels and the FSM is in IDLE; a load/store request after reset is granted immediately.
